// File: rtl/sc_psrandom_arbiter_pkg.sv
// Shared types and constants for the pseudo-random source arbiter.
// Used by sc_psrandom_arbiter and its picker sub-module.
package sc_psrandom_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // Capture-register strobes are active low; this is their idle level.
    localparam logic STROBE_INACTIVE = 1'b1;

    localparam int GRANT_W = 3;

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational winner selection: first request at or above ptr_i, with wrap.
// With SC_PSRANDOM_ARBITER_FIXED_PRIO_EN defined, the lowest requesting index wins.
module sc_rr_picker
    import sc_psrandom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [GRANT_W-1:0] winner_o,
    output logic               valid_o
);

    logic [7:0] req_pad;

`ifdef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        req_pad = '0;
        req_pad[NUM_REQ-1:0] = req_i;
        winner_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_pad[GRANT_W'(i)]) winner_o = GRANT_W'(i);
        end
    end
`else
    logic [GRANT_W-1:0] cand;

    // Scan from the farthest offset down so the nearest match is written last.
    always_comb begin
        req_pad = '0;
        req_pad[NUM_REQ-1:0] = req_i;
        winner_o = '0;
        cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = GRANT_W'((int'(ptr_i) + i) % NUM_REQ);
            if (req_pad[cand]) winner_o = cand;
        end
    end
`endif

    assign valid_o = |req_i;

endmodule

// File: rtl/sc_psrandom_arbiter.sv
// Arbiter/sequencer sharing one pseudo-random source and capture register among requesters.
// Define SC_PSRANDOM_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sc_psrandom_arbiter
    import sc_psrandom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MIN_GAP = 2,
    parameter int GAP_W   = 4
) (
    input  logic               SC_PSRANDOM_ARBITER_CLOCK_50,
    input  logic               SC_PSRANDOM_ARBITER_RESET_InHigh,
    input  logic [NUM_REQ-1:0] SC_PSRANDOM_ARBITER_req_InBUS,
    input  logic               SC_PSRANDOM_ARBITER_clear_InLow,
    output logic [NUM_REQ-1:0] SC_PSRANDOM_ARBITER_ack_OutBUS,
    output logic [GRANT_W-1:0] SC_PSRANDOM_ARBITER_grant_OutBUS,
    output logic               SC_PSRANDOM_ARBITER_busy_Out,
    output logic               SC_PSRANDOM_ARBITER_load_OutLow,
    output logic               SC_PSRANDOM_ARBITER_clear_OutLow
);

    state_t             state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] winner;
    logic               any_req;

`ifdef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [GRANT_W-1:0] rr_q, rr_d;
    logic [GRANT_W-1:0] next_ptr;

    assign rr_ptr   = rr_q;
    assign next_ptr = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : GRANT_W'(grant_q + 3'd1);
`endif

    sc_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i    (SC_PSRANDOM_ARBITER_req_InBUS),
        .ptr_i    (rr_ptr),
        .winner_o (winner),
        .valid_o  (any_req)
    );

    always_ff @(posedge SC_PSRANDOM_ARBITER_CLOCK_50) begin
        if (SC_PSRANDOM_ARBITER_RESET_InHigh) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gap_q   <= '0;
`ifndef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gap_q   <= gap_d;
`ifndef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Clear beats requests in IDLE; requests and clear are not latched elsewhere.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gap_d   = gap_q;
`ifndef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!SC_PSRANDOM_ARBITER_clear_InLow) begin
                    state_d = ST_CLEAR;
                end else if (any_req) begin
                    state_d = ST_LOAD;
                    grant_d = winner;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            ST_LOAD:  state_d = ST_DELIVER;
            ST_DELIVER: begin
`ifndef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
                rr_d = next_ptr;
`endif
                if (MIN_GAP == 0) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(MIN_GAP);
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GAP_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ack is gated by the live request so a withdrawn draw is silently discarded.
    always_comb begin
        SC_PSRANDOM_ARBITER_ack_OutBUS = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            SC_PSRANDOM_ARBITER_ack_OutBUS[i] = (state_q == ST_DELIVER) &&
                                                (grant_q == GRANT_W'(i)) &&
                                                SC_PSRANDOM_ARBITER_req_InBUS[i];
        end
    end

    assign SC_PSRANDOM_ARBITER_grant_OutBUS = grant_q;
    assign SC_PSRANDOM_ARBITER_busy_Out     = (state_q != ST_IDLE);
    assign SC_PSRANDOM_ARBITER_load_OutLow  = (state_q == ST_LOAD)  ? ~STROBE_INACTIVE : STROBE_INACTIVE;
    assign SC_PSRANDOM_ARBITER_clear_OutLow = (state_q == ST_CLEAR) ? ~STROBE_INACTIVE : STROBE_INACTIVE;

endmodule

// File: tb/tb_sc_psrandom_arbiter.sv
// Self-checking bench for sc_psrandom_arbiter (NUM_REQ=2, MIN_GAP=2).
// Acks are checked against an expected queue filled when requests are driven.
module tb_sc_psrandom_arbiter;

    localparam int NUM_REQ = 2;
    localparam int MIN_GAP = 2;
    localparam int GAP_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    logic               clear_n = 1'b1;
    logic [NUM_REQ-1:0] ack;
    logic [2:0]         grant;
    logic               busy;
    logic               load_n;
    logic               clr_n_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [NUM_REQ-1:0] exp_q[$];

    sc_psrandom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MIN_GAP (MIN_GAP),
        .GAP_W   (GAP_W)
    ) dut (
        .SC_PSRANDOM_ARBITER_CLOCK_50     (clk),
        .SC_PSRANDOM_ARBITER_RESET_InHigh (rst),
        .SC_PSRANDOM_ARBITER_req_InBUS    (req),
        .SC_PSRANDOM_ARBITER_clear_InLow  (clear_n),
        .SC_PSRANDOM_ARBITER_ack_OutBUS   (ack),
        .SC_PSRANDOM_ARBITER_grant_OutBUS (grant),
        .SC_PSRANDOM_ARBITER_busy_Out     (busy),
        .SC_PSRANDOM_ARBITER_load_OutLow  (load_n),
        .SC_PSRANDOM_ARBITER_clear_OutLow (clr_n_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        clear_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 30) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && ack !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_ack: ack=%b, required no ack", ack);
            end else begin
                logic [NUM_REQ-1:0] e;
                e = exp_q.pop_front();
                if (ack !== e) begin
                    n_err++;
                    $display("FAIL sb_ack: ack=%b, required %b", ack, e);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp += 5;
        if (ack !== '0)     begin n_err++; $display("FAIL rst_ack: ack=%b, required 00", ack); end
        if (grant !== 3'd0) begin n_err++; $display("FAIL rst_grant: grant=%0d, required 0", grant); end
        if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy: busy=%b, required 0", busy); end
        if (load_n !== 1'b1) begin n_err++; $display("FAIL rst_load: load_n=%b, required 1", load_n); end
        if (clr_n_o !== 1'b1) begin n_err++; $display("FAIL rst_clear: clear_n=%b, required 1", clr_n_o); end
        rst = 1'b0;
        // Reset while requester 1's draw is in LOAD.
        req = 2'b10;
        tick();
        n_cmp += 2;
        if (load_n !== 1'b0) begin n_err++; $display("FAIL midload_load: load_n=%b, required 0", load_n); end
        if (grant !== 3'd1)  begin n_err++; $display("FAIL midload_grant: grant=%0d, required 1", grant); end
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        n_cmp += 4;
        if (load_n !== 1'b1) begin n_err++; $display("FAIL postrst_load: load_n=%b, required 1", load_n); end
        if (ack !== '0)      begin n_err++; $display("FAIL postrst_ack: ack=%b, required 00", ack); end
        if (grant !== 3'd0)  begin n_err++; $display("FAIL postrst_grant: grant=%0d, required 0", grant); end
        if (busy !== 1'b0)   begin n_err++; $display("FAIL postrst_busy: busy=%b, required 0", busy); end
        repeat (8) tick();
    endtask

    task automatic test_single();
        req = 2'b01;
        exp_q.push_back(2'b01);
        tick();
        n_cmp += 2;
        if (load_n !== 1'b0) begin n_err++; $display("FAIL single_load: load_n=%b, required 0", load_n); end
        if (busy !== 1'b1)   begin n_err++; $display("FAIL single_busy1: busy=%b, required 1", busy); end
        tick();
        n_cmp += 3;
        if (ack !== 2'b01)   begin n_err++; $display("FAIL single_ack: ack=%b, required 01", ack); end
        if (grant !== 3'd0)  begin n_err++; $display("FAIL single_grant: grant=%0d, required 0", grant); end
        if (load_n !== 1'b1) begin n_err++; $display("FAIL single_load_off: load_n=%b, required 1", load_n); end
        tick();
        req = '0;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy3: busy=%b, required 1", busy); end
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy4: busy=%b, required 1", busy); end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle5: busy=%b, required 0", busy); end
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] exp_seq [4];
        int nack;
        int last;
`ifdef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`else
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_seq[i]);
        nack = 0;
        last = 0;
        req = 2'b11;
        for (int k = 0; k < 60 && nack < 4; k++) begin
            tick();
            if (ack !== '0) begin
                n_cmp++;
                if (ack !== exp_seq[nack]) begin
                    n_err++;
                    $display("FAIL cont_ack%0d: ack=%b, required %b", nack, ack, exp_seq[nack]);
                end
                if (nack > 0) begin
                    n_cmp++;
                    if (cyc - last != 3 + MIN_GAP) begin
                        n_err++;
                        $display("FAIL cont_spacing%0d: gap=%0d cycles, required %0d", nack, cyc - last, 3 + MIN_GAP);
                    end
                end
                last = cyc;
                nack++;
            end
        end
        n_cmp++;
        if (nack != 4) begin n_err++; $display("FAIL cont_count: acks=%0d, required 4", nack); end
        tick();
        req = '0;
        wait_idle("cont");
    endtask

    task automatic test_clear_priority();
        clear_n = 1'b0;
        req = 2'b10;
        tick();
        n_cmp += 2;
        if (clr_n_o !== 1'b0) begin n_err++; $display("FAIL clr_strobe: clear_n=%b, required 0", clr_n_o); end
        if (load_n !== 1'b1)  begin n_err++; $display("FAIL clr_noload: load_n=%b, required 1", load_n); end
        clear_n = 1'b1;
        exp_q.push_back(2'b10);
        tick();
        n_cmp += 2;
        if (clr_n_o !== 1'b1) begin n_err++; $display("FAIL clr_release: clear_n=%b, required 1", clr_n_o); end
        if (busy !== 1'b0)    begin n_err++; $display("FAIL clr_idle: busy=%b, required 0", busy); end
        tick();
        n_cmp += 2;
        if (load_n !== 1'b0) begin n_err++; $display("FAIL clr_load: load_n=%b, required 0", load_n); end
        if (grant !== 3'd1)  begin n_err++; $display("FAIL clr_grant: grant=%0d, required 1", grant); end
        tick();
        n_cmp++;
        if (ack !== 2'b10) begin n_err++; $display("FAIL clr_ack: ack=%b, required 10", ack); end
        tick();
        req = '0;
        wait_idle("clr");
    endtask

    task automatic test_withdrawn();
        logic [NUM_REQ-1:0] e;
        logic [2:0]         g;
        req = 2'b01;
        tick();
        n_cmp++;
        if (load_n !== 1'b0) begin n_err++; $display("FAIL wd_load: load_n=%b, required 0", load_n); end
        req = '0;
        tick();
        n_cmp += 2;
        if (ack !== '0)    begin n_err++; $display("FAIL wd_noack: ack=%b, required 00", ack); end
        if (busy !== 1'b1) begin n_err++; $display("FAIL wd_busy: busy=%b, required 1", busy); end
        wait_idle("wd");
`ifdef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
        e = 2'b01; g = 3'd0;
`else
        e = 2'b10; g = 3'd1;
`endif
        req = 2'b11;
        exp_q.push_back(e);
        tick();
        n_cmp++;
        if (grant !== g) begin n_err++; $display("FAIL wd_grant: grant=%0d, required %0d", grant, g); end
        tick();
        n_cmp++;
        if (ack !== e) begin n_err++; $display("FAIL wd_ack: ack=%b, required %b", ack, e); end
        tick();
        req = '0;
        wait_idle("wd2");
    endtask

    task automatic test_random();
        int ptr_m;
        int w;
        logic [NUM_REQ-1:0] r;
        do_reset();
        ptr_m = 0;
        for (int n = 0; n < 10; n++) begin
            r = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            w = -1;
`ifdef SC_PSRANDOM_ARBITER_FIXED_PRIO_EN
            for (int o = NUM_REQ - 1; o >= 0; o--) if (r[o]) w = o;
`else
            for (int o = NUM_REQ - 1; o >= 0; o--) if (r[(ptr_m + o) % NUM_REQ]) w = (ptr_m + o) % NUM_REQ;
`endif
            exp_q.push_back(NUM_REQ'(1) << w);
            req = r;
            tick();
            tick();
            n_cmp++;
            if (grant !== 3'(w)) begin
                n_err++;
                $display("FAIL rand_grant%0d: req=%b grant=%0d, required %0d", n, r, grant, w);
            end
            tick();
            req = '0;
            wait_idle("rand");
            ptr_m = (w + 1) % NUM_REQ;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_clear_priority();
        test_withdrawn();
        test_random();
        repeat (3) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d expected acks never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sc_psrandom_arbiter.md
Name: sc_psrandom_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pseudo-random source and its capture register between NUM_REQ requesters.
- Sits between the debounced button/state-machine layer and the general register: it drives the register's active-low load/clear strobes and returns a one-cycle ack to the winning requester when the register holds that requester's draw.
- Enforces a minimum spacing of MIN_GAP cycles between consecutive draws so the generator advances between samples.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MIN_GAP, 2, idle cycles forced after each delivery before the next arbitration (0..15).
- GAP_W, 4, width of the gap counter; must hold MIN_GAP.

Ports:
- SC_PSRANDOM_ARBITER_CLOCK_50  in  1  system clock; all logic on rising edge.
- SC_PSRANDOM_ARBITER_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_PSRANDOM_ARBITER_req_InBUS  in  NUM_REQ  per-requester draw request, level, held until ack.
- SC_PSRANDOM_ARBITER_clear_InLow  in  1  debounced clear command, active low.
- SC_PSRANDOM_ARBITER_ack_OutBUS  out  NUM_REQ  one-hot, one-cycle ack; register output valid this cycle.
- SC_PSRANDOM_ARBITER_grant_OutBUS  out  3  index of current/last granted requester.
- SC_PSRANDOM_ARBITER_busy_Out  out  1  high in every state except IDLE.
- SC_PSRANDOM_ARBITER_load_OutLow  out  1  load strobe to the capture register, active low.
- SC_PSRANDOM_ARBITER_clear_OutLow  out  1  clear strobe to the capture register, active low.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ack=0, grant=0, busy=0, load_OutLow=1, clear_OutLow=1, rr pointer=0, gap counter=0.
- Reset wins over everything, including mid-transaction; any in-flight draw is abandoned with no ack.
- States: IDLE, CLEAR, LOAD, DELIVER, GAP. All outputs are Moore-decoded from registered state/grant.
- IDLE:
  - clear_InLow=0 -> CLEAR. Clear has priority over any request.
  - Else if any req -> LOAD. grant <= first set req at or after the rr pointer, searching upward with wrap.
  - Else stay in IDLE.
- CLEAR: clear_OutLow=0 for exactly one cycle -> IDLE. A held-low clear re-clears on each IDLE visit; requests wait meanwhile.
- LOAD: load_OutLow=0 for exactly one cycle; the register captures generator data at the end of this cycle -> DELIVER.
- DELIVER:
  - If req[grant] is still 1, ack[grant]=1 for this cycle only and register output is valid.
  - If req[grant] dropped, no ack and the draw is discarded.
  - Either way: rr pointer <= (grant+1) mod NUM_REQ; gap counter <= MIN_GAP; -> GAP, or -> IDLE if MIN_GAP=0.
- GAP: decrement the counter; when it reaches 1 -> IDLE. Requests and clear are ignored here and are not latched; levels are simply re-sampled in IDLE.
- Latency: req sampled high in IDLE at edge N -> LOAD during cycle N+1 -> ack during cycle N+2. Minimum draw period is 3+MIN_GAP cycles.
- Requester protocol: deassert req in the cycle after ack. If req is still high when the arbiter returns to IDLE, it is a new request, but the rr pointer has already moved past it.
- Simultaneous requests: exactly one grant, chosen by the rr pointer. With all requesters requesting continuously, service is strictly cyclic 0,1,...,NUM_REQ-1.
- Request bits at index >= NUM_REQ do not exist; the grant_OutBUS upper bits are 0.

Optional Feature:
- Macro: SC_PSRANDOM_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest requesting index always wins; rr pointer not implemented. Starvation of higher indices is accepted.
- Undefined (default): round-robin as specified above.

Decomposition:
- Shared package sc_psrandom_arbiter_pkg holds:
  - state enum (IDLE, CLEAR, LOAD, DELIVER, GAP) with fixed 3-bit encoding;
  - the strobe inactive level constant (1'b1);
  - the grant index width constant (3).
- One sub-module: sc_rr_picker, purely combinational. Inputs: req vector and pointer. Outputs: winner index and any-valid. Fixed-priority mode is selected inside it by the macro.

Test Plan:
- Reset mid-LOAD: assert RESET_InHigh for 1 cycle -> next cycle IDLE, load_OutLow=1, ack=0, grant=0, no later ack.
- Single request: req=01 at edge N -> load_OutLow=0 in cycle N+1, ack=01 in cycle N+2, busy high N+1..N+4 (MIN_GAP=2), IDLE at N+5.
- Contention: req=11 held continuously, acks re-asserted per protocol -> ack sequence 01,10,01,10, with ack pulses exactly 5 cycles apart.
- Clear priority: clear_InLow=0 and req=10 together in IDLE -> clear_OutLow=0 one cycle, then LOAD for requester 1, ack=10 two cycles later.
- Withdrawn request: req=01 dropped during LOAD -> no ack in DELIVER; pointer advances to 1; next req=11 grants requester 1 first.
- FIXED_PRIO_EN defined, req=11 held -> ack always 01; requester 1 is never acked while requester 0 requests.
